// File: rtl/traffic_light_pkg.sv
// Shared types and helpers for the traffic-light safety monitor.
// Lamp/sample vectors are packed as {green, yellow, red}.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_RED
  } phase_t;

  typedef enum logic [1:0] {
    MS_INIT,
    MS_PASS,
    MS_FAULT
  } mon_state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ILLEGAL  = 2'd1;
  localparam logic [1:0] FC_SEQUENCE = 2'd2;
  localparam logic [1:0] FC_DWELL    = 2'd3;

  localparam logic [2:0] LAMPS_GREEN  = 3'b100;
  localparam logic [2:0] LAMPS_YELLOW = 3'b010;
  localparam logic [2:0] LAMPS_RED    = 3'b001;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_GREEN;
    endcase
  endfunction

  // Only meaningful for one-hot input; anything else decodes to red.
  function automatic phase_t lamps_to_phase(input logic [2:0] lamps);
    case (lamps)
      LAMPS_GREEN:  return PH_GREEN;
      LAMPS_YELLOW: return PH_YELLOW;
      default:      return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_blink_gen.sv
// Fail-safe flash generator: BLINK_HALF cycles on, BLINK_HALF cycles off.
// While disabled it parks at the start of an on-half so every enable begins lit.
module light_blink_gen #(
  parameter int CNT_W      = 8,
  parameter int BLINK_HALF = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic blink
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_q, on_d;

  always_comb begin
    cnt_d = cnt_q;
    on_d  = on_q;
    if (!enable) begin
      cnt_d = '0;
      on_d  = 1'b1;
    end else if (cnt_q == HALF_LAST) begin
      cnt_d = '0;
      on_d  = ~on_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
    end
  end

  assign blink = on_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp pass-through with legality, order and minimum-dwell checking; any
// violation latches a fault code and switches the lamps to flashing red.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_RED    = 6,
  parameter int BLINK_HALF = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       green_in,
  input  logic       yellow_in,
  input  logic       red_in,
  input  logic       fault_clr,
  output logic       lamp_green,
  output logic       lamp_yellow,
  output logic       lamp_red,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MIN_R_C   = CNT_W'(MIN_RED);

  function automatic logic [CNT_W-1:0] min_dwell(input phase_t p);
    case (p)
      PH_GREEN:  return MIN_G_C;
      PH_YELLOW: return MIN_Y_C;
      default:   return MIN_R_C;
    endcase
  endfunction

  logic [2:0]       samp_q;
  mon_state_t       state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             first_q, first_d;
  logic [2:0]       lamps_q, lamps_d;
  logic [1:0]       code_q, code_d;

  phase_t           samp_phase;
  logic             samp_onehot;
  logic             blink_en;
  logic             blink;

  assign samp_phase  = lamps_to_phase(samp_q);
  assign samp_onehot = $onehot(samp_q);

  // Stage 1: input capture. Stage 2: checks on the captured pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= '0;
      state_q <= MS_INIT;
      phase_q <= PH_RED;
      dwell_q <= '0;
      first_q <= 1'b1;
      lamps_q <= LAMPS_RED;
      code_q  <= FC_NONE;
    end else begin
      samp_q  <= {green_in, yellow_in, red_in};
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      first_q <= first_d;
      lamps_q <= lamps_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    first_d = first_q;
    lamps_d = lamps_q;
    code_d  = code_q;
    case (state_q)
      MS_INIT: begin
        if (samp_q == LAMPS_RED) begin
          state_d = MS_PASS;
          phase_d = PH_RED;
          dwell_d = DWELL_ONE;
          first_d = 1'b1;
          lamps_d = LAMPS_RED;
        end
      end
      MS_PASS: begin
        if (!samp_onehot) begin
          state_d = MS_FAULT;
          code_d  = FC_ILLEGAL;
        end else if (samp_phase == phase_q) begin
          if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
          lamps_d = samp_q;
        end else if (samp_phase != next_phase(phase_q)) begin
          state_d = MS_FAULT;
          code_d  = FC_SEQUENCE;
        end else if (!first_q && (dwell_q < min_dwell(phase_q))) begin
          // The very first red after INIT has an unknown start, so it is exempt.
          state_d = MS_FAULT;
          code_d  = FC_DWELL;
        end else begin
          phase_d = samp_phase;
          dwell_d = DWELL_ONE;
          first_d = 1'b0;
          lamps_d = samp_q;
        end
      end
      MS_FAULT: begin
        if (fault_clr) begin
          state_d = MS_INIT;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = MS_INIT;
        code_d  = FC_NONE;
      end
    endcase
  end

  assign blink_en = (state_q == MS_FAULT);

  light_blink_gen #(
    .CNT_W     (CNT_W),
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .enable(blink_en),
    .blink (blink)
  );

  // Lamps are selected from registered state only, never from raw inputs.
  always_comb begin
    lamp_green  = 1'b0;
    lamp_yellow = 1'b0;
    lamp_red    = 1'b1;
    case (state_q)
      MS_PASS:  {lamp_green, lamp_yellow, lamp_red} = lamps_q;
      MS_FAULT: lamp_red = blink;
      default:  ;
    endcase
  end

  assign fault      = (state_q == MS_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised and directed bench for traffic_light_monitor against a
// pattern-level reference model.
module tb_traffic_light_monitor;

  localparam int MIN_G = 4;
  localparam int MIN_Y = 2;
  localparam int MIN_R = 6;
  localparam int BH    = 8;

  logic       clk = 1'b0;
  logic       rst, green_in, yellow_in, red_in, fault_clr;
  logic       lamp_green, lamp_yellow, lamp_red, fault;
  logic [1:0] fault_code;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_GREEN (MIN_G),
    .MIN_YELLOW(MIN_Y),
    .MIN_RED   (MIN_R),
    .BLINK_HALF(BH),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .green_in   (green_in),
    .yellow_in  (yellow_in),
    .red_in     (red_in),
    .fault_clr  (fault_clr),
    .lamp_green (lamp_green),
    .lamp_yellow(lamp_yellow),
    .lamp_red   (lamp_red),
    .fault      (fault),
    .fault_code (fault_code)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: patterns are ints with green=4, yellow=2, red=1.
  int m_mode;   // 0 init, 1 pass, 2 fault
  int m_samp, m_phase, m_run, m_first, m_lamps, m_code, m_age;

  function automatic int succ_of(input int p);
    return (p == 4) ? 2 : (p == 2) ? 1 : 4;
  endfunction

  function automatic int min_of(input int p);
    return (p == 4) ? MIN_G : (p == 2) ? MIN_Y : MIN_R;
  endfunction

  task automatic model_edge(input int pat, input bit clr, input bit r);
    int v;
    v = 0;
    if (r) begin
      m_mode = 0; m_samp = 0; m_code = 0; m_age = 0;
      return;
    end
    case (m_mode)
      0: if (m_samp == 1) begin
        m_mode = 1; m_phase = 1; m_run = 1; m_first = 1; m_lamps = 1;
      end
      1: begin
        if ($countones(m_samp) != 1) v = 1;
        else if (m_samp == m_phase) m_run = (m_run < 255) ? m_run + 1 : 255;
        else if (m_samp != succ_of(m_phase)) v = 2;
        else if (m_first == 0 && m_run < min_of(m_phase)) v = 3;
        else begin
          m_phase = m_samp; m_run = 1; m_first = 0; m_lamps = m_samp;
        end
        if (v != 0) begin
          m_mode = 2; m_code = v; m_age = 0;
        end
      end
      default: if (clr) begin
        m_mode = 0; m_code = 0;
      end else m_age++;
    endcase
    m_samp = pat;
  endtask

  function automatic int exp_lamps();
    if (m_mode == 0) return 1;
    if (m_mode == 1) return m_lamps;
    return (((m_age / BH) % 2) == 0) ? 1 : 0;
  endfunction

  function automatic int lamps_now();
    return {29'd0, lamp_green, lamp_yellow, lamp_red};
  endfunction

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic step(input int pat, input bit clr = 1'b0, input bit r = 1'b0);
    int p;
    p = pat;
    {green_in, yellow_in, red_in} = p[2:0];
    fault_clr = clr;
    rst = r;
    @(posedge clk);
    model_edge(pat, clr, r);
    @(negedge clk);
    chk("lamps", lamps_now(), exp_lamps());
    chk("fault", {31'd0, fault}, (m_mode == 2) ? 1 : 0);
    chk("code", {30'd0, fault_code}, m_code);
  endtask

  function automatic int ctrl_pat(input int t);
    int k;
    k = t % 12;
    return (k < 6) ? 1 : (k < 10) ? 4 : 2;
  endfunction

  initial begin
    int prev, found, cp, left, pat;
    m_mode = 0; m_samp = 0; m_code = 0; m_age = 0;
    m_phase = 1; m_run = 0; m_first = 1; m_lamps = 1;
    {green_in, yellow_in, red_in} = 3'b000;
    fault_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_lamps", lamps_now(), 1);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_code", {30'd0, fault_code}, 0);

    // Well-behaved controller: lamps lag the controller by one bench step.
    prev = 0;
    for (int t = 0; t < 100; t++) begin
      step(ctrl_pat(t));
      if (t >= 1) chk("delay", lamps_now(), prev);
      chk("nofault", {31'd0, fault}, 0);
      prev = ctrl_pat(t);
    end

    // Illegal pattern in green.
    step(1); step(1);
    step(4); step(4);
    step(5);
    step(4);
    chk("ill_fault", {31'd0, fault}, 1);
    chk("ill_code", {30'd0, fault_code}, 1);
    for (int i = 0; i < 2 * BH + 4; i++) begin
      step(4);
      chk("ill_blink", lamps_now(), ((((i + 1) / BH) % 2) == 0) ? 1 : 0);
    end

    // Clear, then a one-cycle first red is dwell-exempt.
    step(4, 1);
    chk("clr_lamps", lamps_now(), 1);
    chk("clr_fault", {31'd0, fault}, 0);
    chk("clr_code", {30'd0, fault_code}, 0);
    step(1);
    repeat (4) step(4);
    repeat (2) step(2);
    repeat (MIN_R) step(1);
    chk("exempt_fault", {31'd0, fault}, 0);

    // Green held one cycle short.
    repeat (MIN_G - 1) step(4);
    step(2); step(2);
    chk("short_code", {30'd0, fault_code}, 3);

    // Green held exactly the minimum.
    step(0, 1);
    step(1);
    repeat (MIN_G) step(4);
    repeat (MIN_Y) step(2);
    step(1);
    chk("exact_fault", {31'd0, fault}, 0);

    // Green followed by red skips yellow.
    repeat (MIN_R - 1) step(1);
    repeat (5) step(4);
    step(1); step(1);
    chk("seq_code", {30'd0, fault_code}, 2);
    chk("seq_lamps", lamps_now(), 1);

    // Reset during the off half of the flash.
    found = 0;
    for (int i = 0; i < 3 * BH && found == 0; i++) begin
      step(1);
      if (lamp_red == 1'b0) found = 1;
    end
    chk("off_half_seen", found, 1);
    step(1, 0, 1);
    chk("midblink_lamps", lamps_now(), 1);
    chk("midblink_fault", {31'd0, fault}, 0);
    chk("midblink_code", {30'd0, fault_code}, 0);

    // Randomised controller with occasional glitches, clears and resets.
    cp = 1;
    left = $urandom_range(1, 9);
    for (int i = 0; i < 1500; i++) begin
      pat = cp;
      if ($urandom_range(0, 99) < 4) pat = $urandom_range(0, 7);
      step(pat, ($urandom_range(0, 99) < 4), ($urandom_range(0, 299) == 0));
      left--;
      if (left == 0) begin
        cp = succ_of(cp);
        left = $urandom_range(1, 9);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Safety monitor and lamp driver placed directly downstream of the traffic-light controller. It consumes the controller's three one-hot phase outputs and passes them through to the physical lamp drivers while checking pattern legality, phase order (green→yellow→red→green) and minimum dwell per phase. On any violation it latches a fault code and forces the lamps into a flashing-red fail-safe mode until software clears it.

## Interface
- MIN_GREEN, 4, minimum legal green dwell in cycles
- MIN_YELLOW, 2, minimum legal yellow dwell in cycles
- MIN_RED, 6, minimum legal red dwell in cycles
- BLINK_HALF, 8, cycles per on and per off half-period of the fail-safe red flash
- CNT_W, 8, width of dwell and blink counters; all MIN_* and BLINK_HALF must be < 2^CNT_W

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- green_in  input  1  controller green phase
- yellow_in  input  1  controller yellow phase
- red_in  input  1  controller red phase
- fault_clr  input  1  single-cycle fault acknowledge; honoured only in FAULT
- lamp_green  output  1  green lamp drive
- lamp_yellow  output  1  yellow lamp drive
- lamp_red  output  1  red lamp drive
- fault  output  1  latched fault flag
- fault_code  output  2  0 none, 1 ILLEGAL_PATTERN, 2 BAD_SEQUENCE, 3 SHORT_DWELL

## Operation
- Inputs registered once into samp_{g,y,r}; all checks use samp, never raw inputs.
- States: INIT, PASS, FAULT. Reset → INIT.
- INIT: lamps steady red only, fault=0. Waits for samp == red-only; then → PASS with phase=RED, dwell=1, first_phase=1. All other patterns ignored in INIT.
- PASS: lamps follow samp. Dwell counter increments each cycle samp equals phase, saturating at 2^CNT_W−1.
- PASS checks on each cycle, priority 1 > 2 > 3:
  - 1: samp not exactly one-hot (zero or multiple bits).
  - 2: samp one-hot, differs from phase, and is not the successor phase.
  - 3: legal successor, but dwell < MIN_<old phase> and first_phase=0.
- Legal change with no violation: phase ← new, dwell ← 1, first_phase ← 0.
- Any violation: → FAULT, fault=1, fault_code latched; the offending pattern never reaches the lamps.
- FAULT: lamp_green=lamp_yellow=0; lamp_red on BLINK_HALF cycles, off BLINK_HALF cycles, repeating, starting with on. Inputs ignored; fault_code held.
- fault_clr=1 in FAULT → INIT next edge, fault=0, fault_code=0, blink counter reset. fault_clr outside FAULT has no effect.
- rst in any state, including mid-blink, → INIT with reset outputs on the next edge.

## Timing
- Reset values: lamp_red=1, lamp_green=0, lamp_yellow=0, fault=0, fault_code=0.
- Pass-through latency: an input change at edge k is on the lamps after edge k+2.
- Fault detection: a violating input sampled at edge k gives fault=1, correct code and fail-safe lamps after edge k+2, in place of the bad pattern.
- A controller phase of N cycles yields dwell=N at the change, so a green of exactly MIN_GREEN cycles passes.
- The first red after INIT is dwell-exempt because its true start is unknown.
- Outputs are registered with no combinational input→output path.

## Structure
- Package traffic_light_pkg: phase_t enum (PH_GREEN, PH_YELLOW, PH_RED), mon_state_t (MS_INIT, MS_PASS, MS_FAULT), fault_code constants FC_NONE/FC_ILLEGAL/FC_SEQUENCE/FC_DWELL, and a next_phase function.
- Sub-module light_blink_gen (clk, rst, enable, BLINK_HALF) produces the flash waveform. Counter restarts with output on whenever enable rises.

## Test plan
- Feed the controller (GREEN_TICKS=4, YELLOW_TICKS=2, RED_TICKS=6) for 100 cycles → lamps equal controller outputs delayed 2 cycles; fault stays 0.
- In PASS green, drive green+red for 1 cycle → fault=1 and fault_code=1 two cycles later; lamp_red on 8, off 8, repeating; green/yellow stay 0.
- Drive green for 5 cycles, then red → fault_code=2; lamps never show the red-after-green as a PASS pattern.
- Drive a legal sequence with green held 3 cycles, then yellow → fault_code=3. Repeat with green held 4 cycles → no fault.
- In FAULT, pulse fault_clr → next cycle INIT, steady red, fault=0, code=0. Apply red-only input → PASS, with no dwell fault on the first red even if it lasts 1 cycle.
- Assert rst during the blink off-half → next edge lamp_red=1, fault=0, code=0, state INIT.
